// File: rtl/fixacc_mc_kern.sv
// Multi-channel segmented fixed-point accumulator; carries/borrows ripple one segment per cycle (FIXACC_NEG_EN enables subtract).
// Latency: non-carrying add lands next cycle; a carry chain of n segments holds add_tready low for n cycles; result one cycle after clear.
// Backpressure: one-entry result buffer; clr_ready drops while it is full, add_tready drops during propagation or an accepted clear.
module fixacc_mc_kern #(
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 32,
    parameter int SEG_WIDTH = 128,
    parameter int SEG_STEP  = 64,
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int IW = $clog2(DEPTH),
    localparam int RW = 2 * SEG_WIDTH + IW + 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       add_tvalid,
    output logic                       add_tready,
    input  logic [CW+IW+SEG_WIDTH-1:0] add_tdata,
    input  logic                       add_sign,
    input  logic                       clr_valid,
    input  logic [CW-1:0]              clr_chan,
    output logic                       clr_ready,
    output logic                       res_tvalid,
    input  logic                       res_tready,
    output logic [RW-1:0]              res_tdata
);

    localparam logic [CW:0]        CH_LIM    = (CW + 1)'(CHANNELS);
    localparam logic [IW-1:0]      TOP_SEG   = IW'(DEPTH - 1);
    localparam logic [SEG_WIDTH:0] CARRY_INC = (SEG_WIDTH + 1)'(1) << (SEG_WIDTH - SEG_STEP);

    typedef enum logic {IDLE, PROP} state_t;

    state_t                 state;
    logic [SEG_WIDTH-1:0]   acc [CHANNELS][DEPTH];
    logic [IW-1:0]          max_idx [CHANNELS];
    logic [CHANNELS-1:0]    ovf;
    logic [CW-1:0]          p_chan;
    logic [IW-1:0]          p_seg;
    logic                   res_full;
    logic [RW-1:0]          res_data;

    logic [CW-1:0]          a_chan, a_ch, c_ch;
    logic [IW-1:0]          a_seg, c_max, p_tgt;
    logic [SEG_WIDTH-1:0]   a_mag, a_cur, p_cur, c_hi, c_lo;
    logic [SEG_WIDTH:0]     a_sum, p_sum;
    logic                   a_ok, c_ok, add_fire, clr_fire;

    assign clr_ready  = (state == IDLE) & rstn & ~res_full;
    assign add_tready = (state == IDLE) & rstn & ~(clr_valid & clr_ready);
    assign add_fire   = add_tvalid & add_tready;
    assign clr_fire   = clr_valid & clr_ready;
    assign res_tvalid = res_full;
    assign res_tdata  = res_data;

    assign a_mag  = add_tdata[SEG_WIDTH-1:0];
    assign a_seg  = add_tdata[SEG_WIDTH +: IW];
    assign a_chan = add_tdata[SEG_WIDTH+IW +: CW];
    assign a_ok   = {1'b0, a_chan} < CH_LIM;
    assign c_ok   = {1'b0, clr_chan} < CH_LIM;
    // Out-of-range channels read a harmless in-range index; their writes are suppressed below.
    assign a_ch   = a_ok ? a_chan : '0;
    assign c_ch   = c_ok ? clr_chan : '0;
    assign p_tgt  = p_seg + 1'b1;

    assign a_cur  = acc[a_ch][a_seg];
    assign p_cur  = acc[p_chan][p_tgt];
    assign c_max  = max_idx[c_ch];
    assign c_hi   = acc[c_ch][c_max];
    assign c_lo   = (c_max == '0) ? '0 : acc[c_ch][c_max - 1'b1];

`ifdef FIXACC_NEG_EN
    logic p_neg;
    assign a_sum = add_sign ? ({1'b0, a_cur} - {1'b0, a_mag}) : ({1'b0, a_cur} + {1'b0, a_mag});
    assign p_sum = p_neg ? ({1'b0, p_cur} - CARRY_INC) : ({1'b0, p_cur} + CARRY_INC);
`else
    logic sign_unused;
    assign sign_unused = add_sign;
    assign a_sum = {1'b0, a_cur} + {1'b0, a_mag};
    assign p_sum = {1'b0, p_cur} + CARRY_INC;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            p_chan   <= '0;
            p_seg    <= '0;
            ovf      <= '0;
            res_full <= 1'b0;
            res_data <= '0;
`ifdef FIXACC_NEG_EN
            p_neg    <= 1'b0;
`endif
            for (int c = 0; c < CHANNELS; c++) begin
                max_idx[c] <= '0;
                for (int k = 0; k < DEPTH; k++) acc[c][k] <= '0;
            end
        end else begin
            if (res_full && res_tready) res_full <= 1'b0;

            if (clr_fire && c_ok) begin
                res_full     <= 1'b1;
                res_data     <= {c_hi, c_lo, c_max, ovf[c_ch]};
                ovf[c_ch]    <= 1'b0;
                max_idx[c_ch] <= '0;
                for (int k = 0; k < DEPTH; k++) acc[c_ch][k] <= '0;
            end

            case (state)
                IDLE: begin
                    if (add_fire && a_ok) begin
                        acc[a_ch][a_seg] <= a_sum[SEG_WIDTH-1:0];
                        if (a_seg > max_idx[a_ch]) max_idx[a_ch] <= a_seg;
                        // A carry/borrow out of the top segment has nowhere to go: flag it and stay idle.
                        if (a_sum[SEG_WIDTH]) begin
                            if (a_seg == TOP_SEG) begin
                                ovf[a_ch] <= 1'b1;
                            end else begin
                                state  <= PROP;
                                p_chan <= a_ch;
                                p_seg  <= a_seg;
`ifdef FIXACC_NEG_EN
                                p_neg  <= add_sign;
`endif
                            end
                        end
                    end
                end
                PROP: begin
                    acc[p_chan][p_tgt] <= p_sum[SEG_WIDTH-1:0];
                    if (p_tgt > max_idx[p_chan]) max_idx[p_chan] <= p_tgt;
                    p_seg <= p_tgt;
                    if (!p_sum[SEG_WIDTH]) begin
                        state <= IDLE;
                    end else if (p_tgt == TOP_SEG) begin
                        ovf[p_chan] <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fixacc_mc_kern.sv
// Bench for fixacc_mc_kern at CHANNELS=2, DEPTH=4, 128-bit segments stepped by 64 bits.
module tb_fixacc_mc_kern;

    localparam int RW = 259;
    localparam logic [128:0] STEP = 129'h1 << 64;
    localparam logic [127:0] ONES = {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    localparam logic [127:0] HIGH = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    localparam logic [127:0] P64  = {64'h1, 64'h0};
`ifdef FIXACC_NEG_EN
    localparam bit NEG_EN = 1'b1;
`else
    localparam bit NEG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          add_tvalid, add_tready, add_sign;
    logic [130:0]  add_tdata;
    logic          clr_valid, clr_ready;
    logic [0:0]    clr_chan;
    logic          res_tvalid, res_tready;
    logic [RW-1:0] res_tdata;

    fixacc_mc_kern #(.CHANNELS(2), .DEPTH(4), .SEG_WIDTH(128), .SEG_STEP(64)) dut (
        .clk(clk), .rstn(rstn),
        .add_tvalid(add_tvalid), .add_tready(add_tready), .add_tdata(add_tdata), .add_sign(add_sign),
        .clr_valid(clr_valid), .clr_chan(clr_chan), .clr_ready(clr_ready),
        .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tdata(res_tdata)
    );

    always #5 clk = ~clk;

    // Reference: each channel is four 128-bit segments with a high-water mark and a sticky overflow.
    logic [127:0] m_acc [2][4];
    int           m_max [2];
    bit           m_ovf [2];
    int           n_checks = 0;
    int           n_pass   = 0;
    int           n_fail   = 0;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_max[c] = 0;
            m_ovf[c] = 1'b0;
            for (int k = 0; k < 4; k++) m_acc[c][k] = '0;
        end
    endfunction

    // Returns the number of extra segments touched by the carry/borrow ripple.
    function automatic int model_add(input int c, input int s, input logic [127:0] mag, input bit neg);
        logic [128:0] t;
        bit sub;
        int k, n;
        sub = NEG_EN && neg;
        k = s;
        n = 0;
        t = sub ? ({1'b0, m_acc[c][k]} - {1'b0, mag}) : ({1'b0, m_acc[c][k]} + {1'b0, mag});
        m_acc[c][k] = t[127:0];
        if (k > m_max[c]) m_max[c] = k;
        while (t[128]) begin
            if (k == 3) begin
                m_ovf[c] = 1'b1;
                break;
            end
            k++;
            n++;
            t = sub ? ({1'b0, m_acc[c][k]} - STEP) : ({1'b0, m_acc[c][k]} + STEP);
            m_acc[c][k] = t[127:0];
            if (k > m_max[c]) m_max[c] = k;
        end
        return n;
    endfunction

    function automatic logic [RW-1:0] model_clear(input int c);
        logic [RW-1:0] r;
        logic [127:0] lo;
        int m;
        m  = m_max[c];
        lo = (m == 0) ? '0 : m_acc[c][m-1];
        r  = {m_acc[c][m], lo, 2'(m), m_ovf[c]};
        m_max[c] = 0;
        m_ovf[c] = 1'b0;
        for (int k = 0; k < 4; k++) m_acc[c][k] = '0;
        return r;
    endfunction

    function automatic logic [127:0] rand_mag();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return ONES;
        if (sel == 1) return 128'($urandom_range(1, 100));
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic add_op(input int c, input int s, input logic [127:0] mag, input bit neg);
        int n_exp, lows, k;
        @(negedge clk);
        add_tvalid = 1'b1;
        add_tdata  = {1'(c), 2'(s), mag};
        add_sign   = neg;
        #1;
        k = 0;
        while (!add_tready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("add_wait", RW'(add_tready), RW'(1));
        @(posedge clk);
        #1;
        add_tvalid = 1'b0;
        add_sign   = 1'b0;
        n_exp = model_add(c, s, mag, neg);
        lows = 0;
        @(negedge clk);
        #1;
        while (!add_tready && lows < 40) begin
            lows++;
            @(negedge clk);
            #1;
        end
        check("add_stall", RW'(lows), RW'(n_exp));
    endtask

    task automatic clr_fire(input int c, output logic [RW-1:0] exp);
        int k;
        @(negedge clk);
        clr_valid = 1'b1;
        clr_chan  = 1'(c);
        #1;
        k = 0;
        while (!clr_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("clr_wait", RW'(clr_ready), RW'(1));
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
        exp = model_clear(c);
    endtask

    task automatic res_take(input string tag, input logic [RW-1:0] exp, input bit drain);
        @(negedge clk);
        #1;
        check("res_valid", RW'(res_tvalid), RW'(1));
        check(tag, res_tdata, exp);
        if (drain) begin
            res_tready = 1'b1;
            @(posedge clk);
            #1;
            res_tready = 1'b0;
            @(negedge clk);
            #1;
            check("res_freed", RW'(res_tvalid), RW'(0));
        end
    endtask

    initial begin
        logic [RW-1:0] e, e1;
        int op;
        rstn = 1'b0;
        add_tvalid = 1'b0; add_tdata = '0; add_sign = 1'b0;
        clr_valid = 1'b0; clr_chan = '0; res_tready = 1'b0;
        model_reset();
        #12;
        check("rst_add_tready", RW'(add_tready), RW'(0));
        check("rst_clr_ready", RW'(clr_ready), RW'(0));
        check("rst_res_tvalid", RW'(res_tvalid), RW'(0));
        check("rst_res_tdata", res_tdata, RW'(0));
        @(negedge clk);
        rstn = 1'b1;

        // Basic accumulate, then an add right after the clear must start from zero.
        add_op(0, 0, 128'd5, 1'b0);
        add_op(0, 0, 128'd7, 1'b0);
        clr_fire(0, e);
        add_op(0, 0, 128'd3, 1'b0);
        res_take("res_basic", e, 1'b1);
        clr_fire(0, e);
        res_take("res_after_clr", e, 1'b1);

        // Single carry into seg1.
        add_op(0, 0, ONES, 1'b0);
        add_op(0, 0, 128'd1, 1'b0);
        clr_fire(0, e);
        res_take("res_carry", e, 1'b1);

        // Three-segment chain that falls off the top.
        add_op(1, 1, HIGH, 1'b0);
        add_op(1, 2, HIGH, 1'b0);
        add_op(1, 3, HIGH, 1'b0);
        add_op(1, 0, ONES, 1'b0);
        add_op(1, 0, 128'd1, 1'b0);
        clr_fire(1, e);
        res_take("res_chain_ovf", e, 1'b1);

        // Borrow (plain add when subtraction is compiled out).
        add_op(0, 1, P64, 1'b0);
        add_op(0, 0, 128'd1, 1'b1);
        clr_fire(0, e);
        res_take("res_borrow", e, 1'b1);

        // Full result buffer blocks clears but not adds.
        add_op(1, 0, 128'd4, 1'b0);
        clr_fire(1, e1);
        res_take("res_bp_ch1", e1, 1'b0);
        @(negedge clk);
        clr_valid = 1'b1;
        clr_chan  = 1'b0;
        #1;
        check("bp_clr_ready", RW'(clr_ready), RW'(0));
        check("bp_add_tready", RW'(add_tready), RW'(1));
        add_op(0, 0, 128'd21, 1'b0);
        add_op(0, 3, 128'd5, 1'b0);
        @(negedge clk);
        #1;
        check("bp_clr_still", RW'(clr_ready), RW'(0));
        check("bp_res_stable", res_tdata, e1);
        res_tready = 1'b1;
        #1;
        check("bp_free_cycle", RW'(clr_ready), RW'(0));
        @(posedge clk);
        #1;
        res_tready = 1'b0;
        @(negedge clk);
        #1;
        check("bp_drained", RW'(res_tvalid), RW'(0));
        check("bp_clr_now", RW'(clr_ready), RW'(1));
        @(posedge clk);
        #1;
        clr_valid = 1'b0;
        e = model_clear(0);
        res_take("res_bp_ch0", e, 1'b1);

        // Reset in the middle of a carry chain, with a result pending.
        add_op(1, 2, 128'd9, 1'b0);
        clr_fire(1, e1);
        res_take("res_pre_rst", e1, 1'b0);
        add_op(0, 0, ONES, 1'b0);
        add_op(0, 1, HIGH, 1'b0);
        add_op(0, 2, HIGH, 1'b0);
        add_op(0, 3, HIGH, 1'b0);
        @(negedge clk);
        add_tvalid = 1'b1;
        add_tdata  = {1'b0, 2'd0, 128'd1};
        #1;
        check("rp_add_ready", RW'(add_tready), RW'(1));
        @(posedge clk);
        #1;
        add_tvalid = 1'b0;
        @(negedge clk);
        #1;
        check("rp_in_prop", RW'(add_tready), RW'(0));
        #2;
        rstn = 1'b0;
        #1;
        check("rp_add_tready", RW'(add_tready), RW'(0));
        check("rp_clr_ready", RW'(clr_ready), RW'(0));
        check("rp_res_tvalid", RW'(res_tvalid), RW'(0));
        check("rp_res_tdata", res_tdata, RW'(0));
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rp_release", RW'(add_tready), RW'(1));
        clr_fire(0, e);
        res_take("res_rst_ch0", e, 1'b1);
        clr_fire(1, e);
        res_take("res_rst_ch1", e, 1'b1);

        // Random mix of adds, subtracts and clears.
        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if (op < 8) begin
                add_op($urandom_range(0, 1), $urandom_range(0, 3), rand_mag(), 1'($urandom_range(0, 1)));
            end else begin
                clr_fire($urandom_range(0, 1), e);
                res_take("res_rand", e, 1'b1);
            end
        end
        clr_fire(0, e);
        res_take("res_final0", e, 1'b1);
        clr_fire(1, e);
        res_take("res_final1", e, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fixacc_mc_kern.md
# fixacc_mc_kern

Multi-channel, segmented fixed-point accumulator with carry and borrow propagation. It is the parametrised successor of the single-channel accumulator kernel in the `box_250mhz` fixed-point accumulation path. Each of `CHANNELS` independent accumulators holds `DEPTH` overlapping segments. A write adds to, or subtracts from, one segment, and any carry-out or borrow-out ripples upward one segment per cycle. A per-channel clear drains the two most-significant touched segments through a one-entry result buffer.

## Interface
- `CHANNELS`, 4: number of independent accumulators; must be ≥1.
- `DEPTH`, 32: segments per channel; must be ≥2.
- `SEG_WIDTH`, 128: bits per segment.
- `SEG_STEP`, 64: weight step between segments. Segment k has weight 2^(k·SEG_STEP). Require 0 < SEG_STEP ≤ SEG_WIDTH.
- Derived widths:
  - CW = max(1, clog2(CHANNELS))
  - IW = clog2(DEPTH)
  - RW = 2·SEG_WIDTH + IW + 1
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `add_tvalid`, in, 1: add request valid.
- `add_tready`, out, 1: add request accepted.
- `add_tdata`, in, CW+IW+SEG_WIDTH: {chan, seg, magnitude}, with magnitude in the LSBs.
- `add_sign`, in, 1: 1 means subtract the magnitude; qualified by `add_tvalid`.
- `clr_valid`, in, 1: clear/readout request.
- `clr_chan`, in, CW: channel to clear.
- `clr_ready`, out, 1: clear accepted.
- `res_tvalid`, out, 1: result valid.
- `res_tready`, in, 1: result consumer ready.
- `res_tdata`, out, RW: {seg[max], seg[max-1], max, ovf}, with ovf in the LSB.

## Operation
- Storage:
  - `acc[c][k]`, SEG_WIDTH bits each.
  - `max_idx[c]`: highest segment written since the last clear.
  - `ovf[c]`: sticky flag.
- FSM has two states, IDLE and PROP.
- IDLE, add handshake `(add_tvalid & add_tready)`:
  - Compute sum = acc[c][s] ± magnitude in SEG_WIDTH+1 bits.
  - Store the low SEG_WIDTH bits.
  - Update `max_idx[c]` = max(max_idx[c], s).
  - If bit SEG_WIDTH is set (carry for add, borrow for subtract), latch c, s and the sign, then go to PROP.
- PROP, each cycle:
  - Apply acc[c][s+1] ± 2^(SEG_WIDTH−SEG_STEP) modulo 2^SEG_WIDTH.
  - Update `max_idx[c]` with s+1, then set s ← s+1.
  - If this step carries or borrows again, stay in PROP; otherwise return to IDLE.
- Top segment: a carry or borrow out of segment DEPTH−1, whether from IDLE or from PROP, is dropped. It sets `ovf[c]` and the FSM returns to, or stays in, IDLE.
- Clear handshake `(clr_valid & clr_ready)`:
  - Capture {acc[c][m], (m==0 ? 0 : acc[c][m−1]), m, ovf[c]} into the result buffer, where m = max_idx[c].
  - Zero all segments, `max_idx` and `ovf` of that channel only.
- Handshake rules:
  - add_tready = IDLE & rstn & ~(clr_valid & clr_ready). A clear wins the cycle.
  - clr_ready = IDLE & rstn & result buffer empty.
- Result buffer:
  - One entry.
  - `res_tvalid` = buffer full. It does not depend on `res_tready` (AXI-stream compliant).
  - The entry is freed on `res_tvalid & res_tready`.
  - `res_tdata` stays stable while `res_tvalid` is high.
- Out-of-range `chan` (≥CHANNELS) on either port:
  - The request is accepted and discarded.
  - A discarded clear produces no result.

## Timing
- Reset: all storage is 0, FSM is IDLE, buffer is empty.
  - `res_tvalid`=0, `res_tdata`=0.
  - `add_tready`=0 and `clr_ready`=0 while `rstn` is low.
- Reset asserted mid-PROP aborts propagation. No partial state survives.
- Add without carry: one request per cycle; the result is visible in storage the next cycle.
- Add with carry chain of length n: `add_tready` is low for n cycles after the handshake.
- Clear: `res_tvalid` rises in the cycle after the handshake.
  - The back-to-back clear rate is one per two cycles if `res_tready` is held high.
  - The freeing cycle is not itself clear-ready.
- An add to channel A issued in the cycle after a clear of A sees zeroed storage.

## Configuration
- `FIXACC_NEG_EN` defined:
  - `add_sign` selects subtraction.
  - Borrows propagate as described above.
  - Borrow out of the top segment sets `ovf`.
- `FIXACC_NEG_EN` undefined:
  - `add_sign` is ignored and every request is an add.
  - The subtract datapath and borrow logic are not synthesised.

## Test plan
All scenarios use DEPTH=4, CHANNELS=2, SEG_WIDTH=128, SEG_STEP=64.
- Basic accumulate: add ch0/seg0 5, then 7, then clear ch0 → res = {hi=12, lo=0, max=0, ovf=0}; `add_tready` never drops.
- Single carry: preload ch0/seg0 to 2^128−1, add seg0 1 → seg0=0, seg1=2^64, `add_tready` low exactly 1 cycle; clear → {2^64, 0, 1, 0}.
- Carry chain and top overflow:
  - Set up ch1 seg1..seg3 = 2^128−2^64 and seg0 = 2^128−1.
  - Add seg0 1 → 3 cycles of PROP; seg0..seg3 all 0.
  - Clear → {0, 0, 3, ovf=1}.
- Borrow (`FIXACC_NEG_EN`): add ch0/seg1 2^64, then subtract seg0 1 → seg0 = 2^128−1, seg1 = 0, max=1.
  - Without the macro, the same stimulus gives seg0 = 1.
- Clear backpressure and isolation:
  - Clear ch1 with `res_tready`=0, then request clear ch0 → `clr_ready` stays 0.
  - Adds to ch0 are accepted meanwhile and ch0 is untouched.
  - Raise `res_tready` → ch1 result drains; the ch0 clear is accepted one cycle later.
- Reset mid-PROP: drop `rstn` during a 3-segment carry chain → all outputs reach their reset values asynchronously; after release, clear ch0 → {0, 0, 0, 0}.
